// File: rtl/sparc_psr_unit.sv
// SPARC Processor State Register and Window Invalid Mask.
// Latches ALU condition codes and returns the registered carry to the ALU.
// Tracks CWP for SAVE/RESTORE/RETT/trap entry, with WIM checks and fault pulses.
// Optional macro WRPSR_DELAY_EN: WRPSR commits on the third rising edge after the request.
module sparc_psr_unit #(
  parameter int unsigned NWINDOWS = 8,
  parameter logic [3:0]  IMPL     = 4'h0,
  parameter logic [3:0]  VER      = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        icc_we,
  input  logic        N_in,
  input  logic        Z_in,
  input  logic        V_in,
  input  logic        C_in,
  input  logic        save,
  input  logic        restore,
  input  logic        rett,
  input  logic        trap_entry,
  input  logic        wrpsr_en,
  input  logic [31:0] wrpsr_data,
  input  logic        wrwim_en,
  input  logic [31:0] wrwim_data,
  output logic [31:0] psr_out,
  output logic [31:0] wim_out,
  output logic        carry_out,
  output logic        win_ovf,
  output logic        win_unf,
  output logic        priv_err,
  output logic        illegal_err
);

  localparam int unsigned CWP_W = 5;
  localparam int unsigned FLD_W = 16;
  localparam logic [CWP_W-1:0] CWP_MAX = CWP_W'(NWINDOWS - 1);
  localparam logic [31:0] WIM_MASK = 32'((64'(1) << NWINDOWS) - 64'(1));

  logic [3:0]       icc_q, icc_n;
  logic [3:0]       pil_q, pil_n;
  logic             s_q, s_n;
  logic             ps_q, ps_n;
  logic             et_q, et_n;
  logic [CWP_W-1:0] cwp_q, cwp_n;
  logic [31:0]      wim_q, wim_n;
  logic             ovf_n, unf_n, priv_n, ill_n;

  logic [CWP_W-1:0] cwp_dec, cwp_inc;
  logic [2:0]       ev_cnt;
  logic             multi_ev, trap_go, req_ok, commit;
  logic [FLD_W-1:0] req_fields, commit_fields;
  logic             unused_wrpsr_bits;

  // Writable PSR fields of the request: {icc, PIL, S, PS, ET, CWP}
  assign req_fields        = {wrpsr_data[23:20], wrpsr_data[11:0]};
  assign unused_wrpsr_bits = ^{wrpsr_data[31:24], wrpsr_data[19:12]};

  assign cwp_dec = (cwp_q == '0) ? CWP_MAX : cwp_q - CWP_W'(1);
  assign cwp_inc = (cwp_q == CWP_MAX) ? '0 : cwp_q + CWP_W'(1);

  assign ev_cnt   = 3'(save) + 3'(restore) + 3'(rett) + 3'(trap_entry);
  assign multi_ev = (ev_cnt > 3'd1);
  assign trap_go  = trap_entry && !multi_ev;
  assign req_ok   = wrpsr_en && s_q && ({1'b0, wrpsr_data[4:0]} < 6'(NWINDOWS));

`ifdef WRPSR_DELAY_EN
  logic [1:0]       pend_cnt_q, pend_cnt_n;
  logic [FLD_W-1:0] pend_fields_q, pend_fields_n;

  // Delayed-write countdown; a fresh request replaces the pending one, trap cancels it
  always_comb begin
    pend_cnt_n    = pend_cnt_q;
    pend_fields_n = pend_fields_q;
    commit        = (pend_cnt_q == 2'd1) && !req_ok && !trap_go;
    commit_fields = pend_fields_q;
    if (trap_go) begin
      pend_cnt_n = 2'd0;
    end else if (req_ok) begin
      pend_cnt_n    = 2'd2;
      pend_fields_n = req_fields;
    end else if (pend_cnt_q != 2'd0) begin
      pend_cnt_n = pend_cnt_q - 2'd1;
    end
  end

  // Pending-write registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_cnt_q    <= 2'd0;
      pend_fields_q <= '0;
    end else begin
      pend_cnt_q    <= pend_cnt_n;
      pend_fields_q <= pend_fields_n;
    end
  end
`else
  assign commit        = req_ok;
  assign commit_fields = req_fields;
`endif

  // Next-state: lowest priority first so later updates overwrite their fields
  always_comb begin
    icc_n  = icc_q;
    pil_n  = pil_q;
    s_n    = s_q;
    ps_n   = ps_q;
    et_n   = et_q;
    cwp_n  = cwp_q;
    wim_n  = wim_q;
    ovf_n  = 1'b0;
    unf_n  = 1'b0;
    priv_n = 1'b0;
    ill_n  = 1'b0;

    if (icc_we) icc_n = {N_in, Z_in, V_in, C_in};

    if (multi_ev) begin
      ill_n = 1'b1;
    end else if (save) begin
      if (wim_q[cwp_dec]) ovf_n = 1'b1;
      else                cwp_n = cwp_dec;
    end else if (restore) begin
      if (wim_q[cwp_inc]) unf_n = 1'b1;
      else                cwp_n = cwp_inc;
    end else if (rett) begin
      if (!s_q || et_q) begin
        priv_n = 1'b1;
      end else if (wim_q[cwp_inc]) begin
        unf_n = 1'b1;
      end else begin
        cwp_n = cwp_inc;
        s_n   = ps_q;
        et_n  = 1'b1;
      end
    end

    if (wrpsr_en && !s_q)  priv_n = 1'b1;
    else if (wrpsr_en && !req_ok) ill_n = 1'b1;

    if (commit) begin
      icc_n = commit_fields[15:12];
      pil_n = commit_fields[11:8];
      s_n   = commit_fields[7];
      ps_n  = commit_fields[6];
      et_n  = commit_fields[5];
      cwp_n = commit_fields[4:0];
    end

    if (trap_go) begin
      cwp_n = cwp_dec;
      ps_n  = s_q;
      s_n   = 1'b1;
      et_n  = 1'b0;
    end

    if (wrwim_en) begin
      if (!s_q) priv_n = 1'b1;
      else      wim_n  = wrwim_data & WIM_MASK;
    end
  end

  // State and fault-pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      icc_q       <= '0;
      pil_q       <= '0;
      s_q         <= 1'b1;
      ps_q        <= 1'b0;
      et_q        <= 1'b0;
      cwp_q       <= '0;
      wim_q       <= '0;
      win_ovf     <= 1'b0;
      win_unf     <= 1'b0;
      priv_err    <= 1'b0;
      illegal_err <= 1'b0;
    end else begin
      icc_q       <= icc_n;
      pil_q       <= pil_n;
      s_q         <= s_n;
      ps_q        <= ps_n;
      et_q        <= et_n;
      cwp_q       <= cwp_n;
      wim_q       <= wim_n;
      win_ovf     <= ovf_n;
      win_unf     <= unf_n;
      priv_err    <= priv_n;
      illegal_err <= ill_n;
    end
  end

  assign psr_out   = {IMPL, VER, icc_q, 6'b0, 1'b0, 1'b0, pil_q, s_q, ps_q, et_q, cwp_q};
  assign wim_out   = wim_q;
  assign carry_out = icc_q[0];

endmodule
